// File: rtl/aes_key_schedule.sv
// FIPS-197 KeyExpansion for AES-128/192/256: one 32-bit schedule word per cycle through a
// shared 4-byte S-box group, with every round key held in a word store behind a registered read port.

module sbox_module (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign out_byte = sbox(in_byte);
endmodule

module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_size,
    input  logic [255:0] key_in,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);
    localparam int MAX_NR = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
    localparam int MAX_NK = MAX_NR - 6;
    localparam int DEPTH  = 4 * (MAX_NR + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic [5:0]   nw_q, nw_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   mod_q, mod_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  prev_q, prev_d;
    logic [127:0] rd_key_q, rd_key_d;
    logic         rd_valid_q, rd_valid_d;
    logic         cfg_err_q, cfg_err_d;

    logic [31:0]  word_mem [DEPTH];
    logic         load_en, gen_en, size_ok;
    logic [3:0]   cfg_nk, cfg_nr;
    logic [5:0]   cfg_nw;
    logic [31:0]  cfg_last;
    logic [31:0]  sbox_in, sbox_out, temp, new_word;
    logic [5:0]   rd_base;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        size_ok  = 1'b0;
        cfg_nk   = 4'd4;
        cfg_nr   = 4'd10;
        cfg_nw   = 6'd44;
        cfg_last = key_in[159:128];
        case (key_size)
            2'b00: size_ok = 1'b1;
            2'b01: begin
                size_ok  = (MAX_KEY_BITS >= 192);
                cfg_nk   = 4'd6;
                cfg_nr   = 4'd12;
                cfg_nw   = 6'd52;
                cfg_last = key_in[95:64];
            end
            2'b10: begin
                size_ok  = (MAX_KEY_BITS >= 256);
                cfg_nk   = 4'd8;
                cfg_nr   = 4'd14;
                cfg_nw   = 6'd60;
                cfg_last = key_in[31:0];
            end
            default: size_ok = 1'b0;
        endcase
    end

    // w[i-1] comes straight from a register, so the S-box path is prev_q -> S-box -> XOR -> store.
    assign sbox_in = (mod_q == 3'd0) ? {prev_q[23:0], prev_q[31:24]} : prev_q;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox_module u_sbox (
            .in_byte  (sbox_in[8*b +: 8]),
            .out_byte (sbox_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_q;
        if (mod_q == 3'd0) begin
            temp = sbox_out ^ {rcon_q, 24'h000000};
        end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
            temp = sbox_out;
        end
    end

    assign new_word = word_mem[idx_q - {2'b00, nk_q}] ^ temp;
    assign rd_base  = {rd_round, 2'b00};

    always_comb begin
        state_d    = state_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        nw_d       = nw_q;
        idx_d      = idx_q;
        mod_d      = mod_q;
        rcon_d     = rcon_q;
        prev_d     = prev_q;
        cfg_err_d  = cfg_err_q;
        load_en    = 1'b0;
        gen_en     = 1'b0;
        rd_key_d   = 128'h0;
        rd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (size_ok) begin
                        load_en   = 1'b1;
                        state_d   = ST_GEN;
                        cfg_err_d = 1'b0;
                        nk_d      = cfg_nk;
                        nr_d      = cfg_nr;
                        nw_d      = cfg_nw;
                        idx_d     = {2'b00, cfg_nk};
                        mod_d     = 3'd0;
                        rcon_d    = 8'h01;
                        prev_d    = cfg_last;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                gen_en = 1'b1;
                idx_d  = idx_q + 6'd1;
                prev_d = new_word;
                mod_d  = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                if (idx_q == nw_q - 6'd1) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The read decision uses the current state, so a restart edge still serves a DONE read.
        if (state_q == ST_DONE && rd_round <= nr_q) begin
            rd_key_d   = {word_mem[rd_base], word_mem[rd_base + 6'd1],
                          word_mem[rd_base + 6'd2], word_mem[rd_base + 6'd3]};
            rd_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            nk_q       <= 4'd0;
            nr_q       <= 4'd0;
            nw_q       <= 6'd0;
            idx_q      <= 6'd0;
            mod_q      <= 3'd0;
            rcon_q     <= 8'h00;
            prev_q     <= 32'h0;
            rd_key_q   <= 128'h0;
            rd_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            nw_q       <= nw_d;
            idx_q      <= idx_d;
            mod_q      <= mod_d;
            rcon_q     <= rcon_d;
            prev_q     <= prev_d;
            rd_key_q   <= rd_key_d;
            rd_valid_q <= rd_valid_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // NOTE: the word store has no reset; reads are gated by DONE, so stale contents are never exposed.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(cfg_nk)) word_mem[j] <= key_in[255 - 32*j -: 32];
            end
        end else if (gen_en) begin
            word_mem[idx_q] <= new_word;
        end
    end

    assign rd_key   = rd_key_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == ST_GEN);
    assign done     = (state_q == ST_DONE);
    assign cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed-vector bench for aes_key_schedule using the FIPS-197 A.1/A.2/A.3 key expansions,
// plus a MAX_KEY_BITS=128 instance for the size-limit check.

module tb_aes_key_schedule;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_55aa55aa};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hcafef00d_12345678};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk, reset;
    logic         start, start_s;
    logic [1:0]   key_size, key_size_s;
    logic [255:0] key_in;
    logic [3:0]   rd_round, rd_round_s;
    logic [127:0] rd_key, rd_key_s;
    logic         rd_valid, busy, done, cfg_err;
    logic         rd_valid_s, busy_s, done_s, cfg_err_s;

    int checks = 0;
    int errors = 0;

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .reset(reset), .start(start), .key_size(key_size), .key_in(key_in),
        .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    aes_key_schedule #(.MAX_KEY_BITS(128)) dut_small (
        .clk(clk), .reset(reset), .start(start_s), .key_size(key_size_s), .key_in(key_in),
        .rd_round(rd_round_s), .rd_key(rd_key_s), .rd_valid(rd_valid_s),
        .busy(busy_s), .done(done_s), .cfg_err(cfg_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] size, input logic [255:0] key);
        key_size = size;
        key_in   = key;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_key(input logic [3:0] r, output logic [127:0] k, output logic v);
        rd_round = r;
        tick();
        k = rd_key;
        v = rd_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy, done, rd_valid, cfg_err} !== 4'b0000 || rd_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_hold: busy/done/valid/err=%b rd_key=%h, required 0000 and 0",
                     {busy, done, rd_valid, cfg_err}, rd_key);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, done, rd_valid, cfg_err} !== 4'b0000 || rd_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_idle: busy/done/valid/err=%b rd_key=%h, required 0000 and 0",
                     {busy, done, rd_valid, cfg_err}, rd_key);
        end
    endtask

    task automatic test_aes128();
        int cycles;
        logic [127:0] k;
        logic v;
        pulse_start(2'b00, K128);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL aes128_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done(cycles);
        checks++;
        if (cycles != 40) begin
            errors++;
            $display("FAIL aes128_latency: %0d cycles, required 40", cycles);
        end
        read_key(4'd0, k, v);
        checks++;
        if (k !== R128_0 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes128_r0: key=%h valid=%b, required %h valid=1", k, v, R128_0);
        end
        read_key(4'd1, k, v);
        checks++;
        if (k !== R128_1 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes128_r1: key=%h valid=%b, required %h valid=1", k, v, R128_1);
        end
        read_key(4'd10, k, v);
        checks++;
        if (k !== R128_10 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes128_r10: key=%h valid=%b, required %h valid=1", k, v, R128_10);
        end
        read_key(4'd11, k, v);
        checks++;
        if (k !== 128'h0 || v !== 1'b0) begin
            errors++;
            $display("FAIL aes128_r11: key=%h valid=%b, required 0 valid=0", k, v);
        end
    endtask

    task automatic test_illegal_size();
        logic [127:0] k;
        logic v;
        pulse_start(2'b11, K256);
        checks++;
        if (cfg_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_flags: cfg_err=%b done=%b busy=%b, required 1 1 0", cfg_err, done, busy);
        end
        read_key(4'd10, k, v);
        checks++;
        if (k !== R128_10 || v !== 1'b1) begin
            errors++;
            $display("FAIL illegal_keep_r10: key=%h valid=%b, required %h valid=1", k, v, R128_10);
        end
    endtask

    task automatic test_aes192();
        int cycles;
        logic [127:0] k;
        logic v;
        pulse_start(2'b01, K192);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL aes192_accept: cfg_err=%b busy=%b, required 0 1", cfg_err, busy);
        end
        wait_done(cycles);
        checks++;
        if (cycles != 46) begin
            errors++;
            $display("FAIL aes192_latency: %0d cycles, required 46", cycles);
        end
        read_key(4'd0, k, v);
        checks++;
        if (k !== R192_0 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes192_r0: key=%h valid=%b, required %h valid=1", k, v, R192_0);
        end
        read_key(4'd1, k, v);
        checks++;
        if (k !== R192_1 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes192_r1: key=%h valid=%b, required %h valid=1", k, v, R192_1);
        end
        read_key(4'd12, k, v);
        checks++;
        if (k !== R192_12 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes192_r12: key=%h valid=%b, required %h valid=1", k, v, R192_12);
        end
        read_key(4'd13, k, v);
        checks++;
        if (k !== 128'h0 || v !== 1'b0) begin
            errors++;
            $display("FAIL aes192_r13: key=%h valid=%b, required 0 valid=0", k, v);
        end
    endtask

    task automatic test_aes256();
        int cycles;
        logic [127:0] k;
        logic v;
        pulse_start(2'b10, K256);
        wait_done(cycles);
        checks++;
        if (cycles != 52) begin
            errors++;
            $display("FAIL aes256_latency: %0d cycles, required 52", cycles);
        end
        read_key(4'd1, k, v);
        checks++;
        if (k !== R256_1 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes256_r1: key=%h valid=%b, required %h valid=1", k, v, R256_1);
        end
        read_key(4'd2, k, v);
        checks++;
        if (k !== R256_2 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes256_r2: key=%h valid=%b, required %h valid=1", k, v, R256_2);
        end
        read_key(4'd14, k, v);
        checks++;
        if (k !== R256_14 || v !== 1'b1) begin
            errors++;
            $display("FAIL aes256_r14: key=%h valid=%b, required %h valid=1", k, v, R256_14);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        logic [127:0] k;
        logic v;
        rd_round = 4'd14;
        pulse_start(2'b00, K128);
        checks++;
        if (rd_valid !== 1'b1 || rd_key !== R256_14) begin
            errors++;
            $display("FAIL b2b_read_on_accept: key=%h valid=%b, required %h valid=1", rd_key, rd_valid, R256_14);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", done, busy);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_key !== 128'h0) begin
            errors++;
            $display("FAIL b2b_read_after: key=%h valid=%b, required 0 valid=0", rd_key, rd_valid);
        end
        wait_done(cycles);
        checks++;
        if (cycles + 1 != 40) begin
            errors++;
            $display("FAIL b2b_latency: %0d cycles, required 40", cycles + 1);
        end
        read_key(4'd10, k, v);
        checks++;
        if (k !== R128_10 || v !== 1'b1) begin
            errors++;
            $display("FAIL b2b_r10: key=%h valid=%b, required %h valid=1", k, v, R128_10);
        end
    endtask

    task automatic test_midrun_start();
        int cycles;
        logic [127:0] k;
        logic v;
        pulse_start(2'b00, K128);
        repeat (19) tick();
        pulse_start(2'b10, K256);
        checks++;
        if (busy !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_start_ignored: busy=%b cfg_err=%b, required 1 0", busy, cfg_err);
        end
        wait_done(cycles);
        checks++;
        if (cycles != 20) begin
            errors++;
            $display("FAIL midrun_start_latency: %0d remaining cycles, required 20", cycles);
        end
        read_key(4'd10, k, v);
        checks++;
        if (k !== R128_10 || v !== 1'b1) begin
            errors++;
            $display("FAIL midrun_start_r10: key=%h valid=%b, required %h valid=1", k, v, R128_10);
        end
    endtask

    task automatic test_midrun_reset();
        int cycles;
        logic [127:0] k;
        logic v;
        pulse_start(2'b00, K128);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, done, rd_valid, cfg_err} !== 4'b0000 || rd_key !== 128'h0) begin
            errors++;
            $display("FAIL midrun_reset: busy/done/valid/err=%b rd_key=%h, required 0000 and 0",
                     {busy, done, rd_valid, cfg_err}, rd_key);
        end
        reset = 1'b0;
        tick();
        pulse_start(2'b00, K128);
        wait_done(cycles);
        checks++;
        if (cycles != 40) begin
            errors++;
            $display("FAIL post_reset_latency: %0d cycles, required 40", cycles);
        end
        read_key(4'd1, k, v);
        checks++;
        if (k !== R128_1 || v !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_r1: key=%h valid=%b, required %h valid=1", k, v, R128_1);
        end
        read_key(4'd10, k, v);
        checks++;
        if (k !== R128_10 || v !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_r10: key=%h valid=%b, required %h valid=1", k, v, R128_10);
        end
    endtask

    task automatic test_max128();
        int cycles;
        key_in     = K128;
        key_size_s = 2'b00;
        start_s    = 1'b1;
        tick();
        start_s    = 1'b0;
        cycles     = 0;
        while (done_s !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles != 40 || cfg_err_s !== 1'b0) begin
            errors++;
            $display("FAIL small_aes128: %0d cycles cfg_err=%b, required 40 and 0", cycles, cfg_err_s);
        end
        rd_round_s = 4'd10;
        tick();
        checks++;
        if (rd_key_s !== R128_10 || rd_valid_s !== 1'b1) begin
            errors++;
            $display("FAIL small_r10: key=%h valid=%b, required %h valid=1", rd_key_s, rd_valid_s, R128_10);
        end
        key_size_s = 2'b10;
        start_s    = 1'b1;
        tick();
        start_s    = 1'b0;
        checks++;
        if (cfg_err_s !== 1'b1 || done_s !== 1'b1 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL small_size_reject: cfg_err=%b done=%b busy=%b, required 1 1 0",
                     cfg_err_s, done_s, busy_s);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start_s    = 1'b0;
        key_size   = 2'b00;
        key_size_s = 2'b00;
        key_in     = '0;
        rd_round   = 4'd0;
        rd_round_s = 4'd0;
        test_reset();
        test_aes128();
        test_illegal_size();
        test_aes192();
        test_aes256();
        test_back_to_back();
        test_midrun_start();
        test_midrun_reset();
        test_max128();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
